// File: rtl/cadr_pkg.sv
// Shared CADR definitions: phase strobes, PDL qualifier bundle and the default PDL pointer width.
package cadr_pkg;

   localparam int unsigned PDL_PTR_W = 10;

   typedef struct packed {
      logic fetch;
      logic alu;
      logic write;
      logic read;
      logic mmu;
   } phase_t;

   typedef struct packed {
      logic srcpdlpop;
      logic srcpdltop;
      logic destpdltop;
      logic destpdl_x;
      logic destpdl_p;
      logic nop;
   } pdl_qual_t;

   // A push that coincides with a live pop cancels into a replace-top.
   function automatic logic pdl_is_push(pdl_qual_t q);
      return q.destpdl_p & ~(~q.nop & q.srcpdlpop);
   endfunction

   function automatic logic pdl_is_pop(pdl_qual_t q);
      return ~q.nop & q.srcpdlpop & ~q.destpdl_p;
   endfunction

endpackage

// File: rtl/pdl_ptr_ctr.sv
// PDL pointer register: load, modulo increment/decrement and sticky wrap flags.
module pdl_ptr_ctr #(
   parameter int unsigned W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         inc,
   input  logic         dec,
   input  logic         err_clr,
   output logic [W-1:0] ptr,
   output logic         ovf,
   output logic         unf
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] ptr_q, ptr_d;
   logic         ovf_q, ovf_d;
   logic         unf_q, unf_d;

   always_comb begin
      ptr_d = ptr_q;
      ovf_d = ovf_q & ~err_clr;
      unf_d = unf_q & ~err_clr;
      if (ld) begin
         ptr_d = ld_val;
      end else if (inc & ~dec) begin
         ptr_d = ptr_q + ONE;
         if (&ptr_q) ovf_d = 1'b1;
      end else if (dec & ~inc) begin
         ptr_d = ptr_q - ONE;
         if (ptr_q == '0) unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign ptr = ptr_q;
   assign ovf = ovf_q;
   assign unf = unf_q;

endmodule

// File: rtl/pdl_stack_ctl.sv
// PDL stack control: pointer/index registers, RAM address select and read/write strobes.
module pdl_stack_ctl
   import cadr_pkg::*;
#(
   parameter int unsigned PTR_W     = PDL_PTR_W,
   parameter int unsigned GUARD_LIM = 2**PTR_W - 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             state_fetch,
   input  logic             state_alu,
   input  logic             state_write,
   input  logic             state_read,
   input  logic             state_mmu,
   input  logic             ptr_sel,
   input  logic             srcpdlpop,
   input  logic             srcpdltop,
   input  logic             destpdltop,
   input  logic             destpdl_x,
   input  logic             destpdl_p,
   input  logic             nop,
   input  logic             ptr_ld,
   input  logic [PTR_W-1:0] ptr_ld_val,
   input  logic             idx_ld,
   input  logic [PTR_W-1:0] idx_ld_val,
   input  logic             err_clr,
   output logic [PTR_W-1:0] pdla,
   output logic [PTR_W-1:0] pdlptr,
   output logic [PTR_W-1:0] pdlidx,
   output logic             pdlwrite,
   output logic             pwp,
   output logic             prp,
   output logic             pdlenb,
   output logic             pdldrive,
   output logic             ovf,
   output logic             unf,
   output logic             guard
);

   localparam logic [PTR_W-1:0] GUARD_V = GUARD_LIM[PTR_W-1:0];

   phase_t    ph;
   pdl_qual_t q;

   assign ph = '{fetch: state_fetch, alu: state_alu, write: state_write,
                 read: state_read, mmu: state_mmu};
   assign q  = '{srcpdlpop: srcpdlpop, srcpdltop: srcpdltop, destpdltop: destpdltop,
                 destpdl_x: destpdl_x, destpdl_p: destpdl_p, nop: nop};

   logic             pwidx_q, pwidx_d;
   logic [PTR_W-1:0] idx_q, idx_d;
   logic             ptr_inc, ptr_dec;

   // Push bumps the pointer before the write phase; pop drops it after the read.
   assign ptr_inc = pdl_is_push(q) & ph.alu;
   assign ptr_dec = pdl_is_pop(q) & ph.fetch;

   pdl_ptr_ctr #(
      .W (PTR_W)
   ) u_ptr_ctr (
      .clk     (clk),
      .reset   (reset),
      .ld      (ptr_ld),
      .ld_val  (ptr_ld_val),
      .inc     (ptr_inc),
      .dec     (ptr_dec),
      .err_clr (err_clr),
      .ptr     (pdlptr),
      .ovf     (ovf),
      .unf     (unf)
   );

   always_comb begin
      pwidx_d = pwidx_q;
      idx_d   = idx_q;
      if (ph.alu | ph.write) pwidx_d = q.destpdl_x;
      if (idx_ld) idx_d = idx_ld_val;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwidx_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         pwidx_q <= pwidx_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      pdlwrite = q.destpdltop | q.destpdl_x | q.destpdl_p;
      pdlenb   = q.srcpdlpop | q.srcpdltop;
      pwp      = pdlwrite & ph.write;
      prp      = pdlenb & ph.read;
      pdldrive = pdlenb & (ph.alu | ph.write | ph.mmu | ph.fetch);
      pdla     = ((ph.read & ptr_sel) | (~ph.read & ~pwidx_q)) ? pdlptr : idx_q;
      guard    = (pdlptr >= GUARD_V);
   end

   assign pdlidx = idx_q;

endmodule

// File: tb/tb_pdl_stack_ctl.sv
// Directed bench for pdl_stack_ctl with hand-computed expectations.
module tb_pdl_stack_ctl;

   localparam int unsigned W = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         state_fetch, state_alu, state_write, state_read, state_mmu;
   logic         ptr_sel;
   logic         srcpdlpop, srcpdltop, destpdltop, destpdl_x, destpdl_p, nop;
   logic         ptr_ld, idx_ld, err_clr;
   logic [W-1:0] ptr_ld_val, idx_ld_val;
   logic [W-1:0] pdla, pdlptr, pdlidx;
   logic         pdlwrite, pwp, prp, pdlenb, pdldrive, ovf, unf, guard;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pdl_stack_ctl dut (
      .clk         (clk),
      .reset       (reset),
      .state_fetch (state_fetch),
      .state_alu   (state_alu),
      .state_write (state_write),
      .state_read  (state_read),
      .state_mmu   (state_mmu),
      .ptr_sel     (ptr_sel),
      .srcpdlpop   (srcpdlpop),
      .srcpdltop   (srcpdltop),
      .destpdltop  (destpdltop),
      .destpdl_x   (destpdl_x),
      .destpdl_p   (destpdl_p),
      .nop         (nop),
      .ptr_ld      (ptr_ld),
      .ptr_ld_val  (ptr_ld_val),
      .idx_ld      (idx_ld),
      .idx_ld_val  (idx_ld_val),
      .err_clr     (err_clr),
      .pdla        (pdla),
      .pdlptr      (pdlptr),
      .pdlidx      (pdlidx),
      .pdlwrite    (pdlwrite),
      .pwp         (pwp),
      .prp         (prp),
      .pdlenb      (pdlenb),
      .pdldrive    (pdldrive),
      .ovf         (ovf),
      .unf         (unf),
      .guard       (guard)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      {state_fetch, state_alu, state_write, state_read, state_mmu} = '0;
      {srcpdlpop, srcpdltop, destpdltop, destpdl_x, destpdl_p, nop} = '0;
      {ptr_sel, ptr_ld, idx_ld, err_clr} = '0;
      ptr_ld_val = '0;
      idx_ld_val = '0;
   endtask

   task automatic load_ptr(input logic [W-1:0] v);
      clr();
      ptr_ld     = 1'b1;
      ptr_ld_val = v;
      step();
      clr();
   endtask

   initial begin
      clr();
      reset = 1'b1;
      #3;
      check("rst_ptr", 32'(pdlptr), 0);
      check("rst_idx", 32'(pdlidx), 0);
      check("rst_pdla", 32'(pdla), 0);
      check("rst_flags", {ovf, unf, guard}, 0);
      step();
      step();
      reset = 1'b0;
      step();

      // Push: pointer advances at end of alu, write addresses new top.
      destpdl_p = 1'b1;
      state_alu = 1'b1;
      #1;
      check("push_pdlwrite", 32'(pdlwrite), 1);
      check("push_alu_pwp", 32'(pwp), 0);
      step();
      check("push_ptr", 32'(pdlptr), 1);
      state_alu   = 1'b0;
      state_write = 1'b1;
      #1;
      check("push_pwp", 32'(pwp), 1);
      check("push_pdla", 32'(pdla), 1);
      step();
      clr();

      // Pop: read old top, then decrement after fetch.
      load_ptr(10'd5);
      srcpdlpop  = 1'b1;
      state_read = 1'b1;
      ptr_sel    = 1'b1;
      #1;
      check("pop_prp", 32'(prp), 1);
      check("pop_pdla", 32'(pdla), 5);
      check("pop_read_drive", 32'(pdldrive), 0);
      step();
      check("pop_ptr_hold", 32'(pdlptr), 5);
      state_read  = 1'b0;
      ptr_sel     = 1'b0;
      state_fetch = 1'b1;
      #1;
      check("pop_drive", 32'(pdldrive), 1);
      check("pop_enb", 32'(pdlenb), 1);
      step();
      check("pop_ptr", 32'(pdlptr), 4);
      clr();

      // nop suppresses the pop.
      srcpdltop   = 1'b1;
      srcpdlpop   = 1'b1;
      nop         = 1'b1;
      state_fetch = 1'b1;
      step();
      check("nop_ptr", 32'(pdlptr), 4);
      clr();

      // Underflow, clear, clear-vs-wrap race, overflow.
      load_ptr(10'd0);
      srcpdlpop   = 1'b1;
      state_fetch = 1'b1;
      step();
      check("unf_ptr", 32'(pdlptr), 10'h3FF);
      check("unf_set", 32'(unf), 1);
      clr();
      err_clr = 1'b1;
      step();
      check("unf_clr", 32'(unf), 0);
      clr();
      load_ptr(10'd0);
      srcpdlpop   = 1'b1;
      state_fetch = 1'b1;
      err_clr     = 1'b1;
      step();
      check("unf_wins_clr", 32'(unf), 1);
      clr();
      err_clr = 1'b1;
      step();
      clr();
      load_ptr(10'h3FF);
      check("guard_hi", 32'(guard), 1);
      destpdl_p = 1'b1;
      state_alu = 1'b1;
      step();
      check("ovf_ptr", 32'(pdlptr), 0);
      check("ovf_set", {ovf, unf}, 2'b10);
      clr();
      // Load beats a same-cycle push and leaves flags alone.
      destpdl_p  = 1'b1;
      state_alu  = 1'b1;
      ptr_ld     = 1'b1;
      ptr_ld_val = 10'd7;
      step();
      check("ld_prio_ptr", 32'(pdlptr), 7);
      check("ld_keeps_ovf", 32'(ovf), 1);
      clr();
      err_clr = 1'b1;
      step();
      check("ovf_clr", 32'(ovf), 0);
      clr();

      // Push+pop in one instruction replaces top.
      destpdl_p  = 1'b1;
      srcpdlpop  = 1'b1;
      state_read = 1'b1;
      ptr_sel    = 1'b1;
      #1;
      check("pp_read_pdla", 32'(pdla), 7);
      step();
      state_read = 1'b0;
      ptr_sel    = 1'b0;
      state_alu  = 1'b1;
      step();
      check("pp_alu_ptr", 32'(pdlptr), 7);
      state_alu   = 1'b0;
      state_write = 1'b1;
      #1;
      check("pp_pwp", 32'(pwp), 1);
      check("pp_pdla", 32'(pdla), 7);
      step();
      state_write = 1'b0;
      state_fetch = 1'b1;
      step();
      check("pp_fetch_ptr", 32'(pdlptr), 7);
      clr();

      // Indexed write.
      idx_ld     = 1'b1;
      idx_ld_val = 10'h20;
      ptr_ld     = 1'b1;
      ptr_ld_val = 10'h10;
      step();
      clr();
      check("idx_ld", 32'(pdlidx), 10'h20);
      destpdl_x = 1'b1;
      state_alu = 1'b1;
      #1;
      check("x_alu_pdla", 32'(pdla), 10'h10);
      step();
      state_alu   = 1'b0;
      state_write = 1'b1;
      #1;
      check("x_write_pdla", 32'(pdla), 10'h20);
      check("x_pwp", 32'(pwp), 1);
      step();
      clr();
      state_read = 1'b1;
      ptr_sel    = 1'b1;
      #1;
      check("x_read_ptr_sel", 32'(pdla), 10'h10);
      ptr_sel = 1'b0;
      #1;
      check("x_read_idx_sel", 32'(pdla), 10'h20);
      clr();
      #1;
      check("x_idle_pdla", 32'(pdla), 10'h20);
      check("x_ptr_kept", 32'(pdlptr), 10'h10);
      step();

      // Guard threshold and reset mid-alu.
      load_ptr(10'h3EF);
      check("guard_below", 32'(guard), 0);
      load_ptr(10'h3F0);
      check("guard_at", 32'(guard), 1);
      destpdl_p = 1'b1;
      state_alu = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      check("arst_ptr", 32'(pdlptr), 0);
      check("arst_guard", 32'(guard), 0);
      check("arst_idx", 32'(pdlidx), 0);
      step();
      clr();
      reset = 1'b0;
      step();
      check("arst_no_inc", 32'(pdlptr), 0);
      check("arst_pdla", 32'(pdla), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
